// File: rtl/std_fp_div_pkg.sv
// Shared types and helpers for the parametrised fixed-point divider.
//   state_e      : controller states
//   iterations() : number of restoring steps for a given width/fraction split
//   sat_max()    : largest representable result, LSB-aligned in MaxWidth bits
//   sat_min()    : most negative representable result (0 when unsigned)
package std_fp_div_pkg;

  // Upper bound on WIDTH supported by the saturation helpers.
  localparam int unsigned MaxWidth = 64;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } state_e;

  function automatic int unsigned iterations(input int unsigned width, input int unsigned frac);
    return width + frac;
  endfunction

  function automatic logic [MaxWidth-1:0] sat_max(input int unsigned width, input bit is_signed);
    logic [MaxWidth-1:0] ones;
    ones = '1;
    return ones >> (MaxWidth - width + (is_signed ? 1 : 0));
  endfunction

  function automatic logic [MaxWidth-1:0] sat_min(input int unsigned width, input bit is_signed);
    logic [MaxWidth-1:0] one;
    one = MaxWidth'(1);
    return is_signed ? (one << (width - 1)) : '0;
  endfunction

endpackage

// File: rtl/std_fp_div_step.sv
// One combinational restoring-division step.
//   acc_i    : partial remainder (WIDTH+1 bits)
//   quo_i    : quotient bits that survive the left shift (ITER-1 bits)
//   din_i    : next dividend bit shifted into the accumulator
//   dvs_i    : divisor magnitude
//   acc_o    : partial remainder after the step
//   quo_o    : quotient after shifting in the new bit
module std_fp_div_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 48
) (
  input  logic [WIDTH:0]    acc_i,
  input  logic [ITER-2:0]   quo_i,
  input  logic              din_i,
  input  logic [WIDTH-1:0]  dvs_i,
  output logic [WIDTH:0]    acc_o,
  output logic [ITER-1:0]   quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    shifted = {acc_i[WIDTH-1:0], din_i};
    // acc_i[WIDTH] is the bit that would shift out; if set, the true value
    // exceeds any WIDTH-bit divisor, so the subtraction must happen.
    ge      = acc_i[WIDTH] | (shifted >= {1'b0, dvs_i});
    diff    = shifted - {1'b0, dvs_i};
    acc_o   = ge ? diff : shifted;
    quo_o   = {quo_i, ge};
  end

endmodule

// File: rtl/std_fp_div_pipe_param.sv
// Iterative restoring fixed-point divider with go/done handshake.
// Latency: done in cycle T+WIDTH+FRAC_WIDTH+2 after a start in cycle T,
// or T+1 for divide-by-zero / zero-dividend fast paths.
//   clk, reset    : clock, synchronous active-high reset
//   go            : request, held by the caller until done
//   left, right   : dividend, divisor (fixed-point)
//   out_quotient  : registered quotient (truncated toward zero, saturating)
//   out_remainder : registered remainder of the extended division
//   done          : one-cycle completion pulse
//   div_by_zero   : last op had right == 0 (cleared at next start)
//   overflow      : last op's quotient saturated (cleared at next start)
module std_fp_div_pipe_param
  import std_fp_div_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned INT_WIDTH  = 16,
  parameter int unsigned FRAC_WIDTH = 16,
  parameter bit          SIGNED     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned Iter = iterations(WIDTH, FRAC_WIDTH);
  localparam int unsigned IdxW = $clog2(Iter);
  localparam logic [MaxWidth-1:0] SatMaxFull = sat_max(WIDTH, SIGNED);
  localparam logic [MaxWidth-1:0] SatMinFull = sat_min(WIDTH, SIGNED);
  localparam logic [WIDTH-1:0] SatMax = SatMaxFull[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SatMin = SatMinFull[WIDTH-1:0];

  if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_bad_split
    $error("INT_WIDTH + FRAC_WIDTH must equal WIDTH");
  end

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH:0]    acc_q, acc_d;
  logic [Iter-1:0]   quo_q, quo_d;
  logic [Iter-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_dvd_q, neg_dvd_d;
  logic [WIDTH-1:0]  out_quo_q, out_quo_d;
  logic [WIDTH-1:0]  out_rem_q, out_rem_d;
  logic              dz_q, dz_d;
  logic              ov_q, ov_d;

  logic              left_neg, right_neg;
  logic [WIDTH-1:0]  left_mag, right_mag;
  logic [WIDTH:0]    acc_step;
  logic [Iter-1:0]   quo_step;
  logic [WIDTH-1:0]  quo_mag;
  logic              hi_zero, ovf;

  always_comb begin
    left_neg  = SIGNED && left[WIDTH-1];
    right_neg = SIGNED && right[WIDTH-1];
    left_mag  = left_neg ? (~left + 1'b1) : left;
    right_mag = right_neg ? (~right + 1'b1) : right;
  end

  std_fp_div_step #(
    .WIDTH (WIDTH),
    .ITER  (Iter)
  ) u_step (
    .acc_i (acc_q),
    .quo_i (quo_q[Iter-2:0]),
    .din_i (dvd_q[Iter-1]),
    .dvs_i (dvs_q),
    .acc_o (acc_step),
    .quo_o (quo_step)
  );

  // Overflow: magnitude must fit WIDTH bits (unsigned) or WIDTH-1 bits
  // (signed), except a negative result of exactly 2^(WIDTH-1).
  always_comb begin
    quo_mag = quo_q[WIDTH-1:0];
    hi_zero = (quo_q[Iter-1:WIDTH] == '0);
    if (SIGNED) begin
      ovf = !hi_zero ||
            (quo_mag[WIDTH-1] && !(neg_res_q && (quo_mag[WIDTH-2:0] == '0)));
    end else begin
      ovf = !hi_zero;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    neg_res_d = neg_res_q;
    neg_dvd_d = neg_dvd_q;
    out_quo_d = out_quo_q;
    out_rem_d = out_rem_q;
    dz_d      = dz_q;
    ov_d      = ov_q;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          idx_d     = '0;
          acc_d     = '0;
          quo_d     = '0;
          dvd_d     = {left_mag, {FRAC_WIDTH{1'b0}}};
          dvs_d     = right_mag;
          neg_res_d = left_neg ^ right_neg;
          neg_dvd_d = left_neg;
          dz_d      = 1'b0;
          ov_d      = 1'b0;
          if (right == '0) begin
            state_d   = StDone;
            out_quo_d = SatMax;
            out_rem_d = '0;
            dz_d      = 1'b1;
          end else if (left == '0) begin
            state_d   = StDone;
            out_quo_d = '0;
            out_rem_d = '0;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        acc_d = acc_step;
        quo_d = quo_step;
        dvd_d = dvd_q << 1;
        idx_d = idx_q + IdxW'(1);
        if (idx_q == IdxW'(Iter - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StDone;
        if (ovf) begin
          out_quo_d = neg_res_q ? SatMin : SatMax;
          out_rem_d = '0;
          ov_d      = 1'b1;
        end else begin
          out_quo_d = neg_res_q ? (~quo_mag + 1'b1) : quo_mag;
          out_rem_d = neg_dvd_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_res_q <= 1'b0;
      neg_dvd_q <= 1'b0;
      out_quo_q <= '0;
      out_rem_q <= '0;
      dz_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      neg_res_q <= neg_res_d;
      neg_dvd_q <= neg_dvd_d;
      out_quo_q <= out_quo_d;
      out_rem_q <= out_rem_d;
      dz_q      <= dz_d;
      ov_q      <= ov_d;
    end
  end

  assign out_quotient  = out_quo_q;
  assign out_remainder = out_rem_q;
  assign done          = (state_q == StDone);
  assign div_by_zero   = dz_q;
  assign overflow      = ov_q;

endmodule

// File: tb/tb_std_fp_div_pipe_param.sv
// Directed test of std_fp_div_pipe_param at default parameters (Q16.16, signed).
module tb_std_fp_div_pipe_param;

  logic        clk;
  logic        reset;
  logic        go;
  logic [31:0] left;
  logic [31:0] right;
  logic [31:0] out_quotient;
  logic [31:0] out_remainder;
  logic        done;
  logic        div_by_zero;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_q;

  std_fp_div_pipe_param #(
    .WIDTH      (32),
    .INT_WIDTH  (16),
    .FRAC_WIDTH (16),
    .SIGNED     (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .left          (left),
    .right         (right),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .done          (done),
    .div_by_zero   (div_by_zero),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start an op, wait (bounded) for done, then check latency, results and hold.
  task automatic do_op(input string tag, input logic [31:0] l, input logic [31:0] r,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic edz, input logic eov, input int lat);
    int k;
    bit seen;
    @(negedge clk);
    go    = 1'b1;
    left  = l;
    right = r;
    @(posedge clk);
    #1;
    k = 1;
    seen = 0;
    // Operand changes after the start must be ignored.
    left  = ~l;
    right = ~r;
    if (lat > 1) begin
      check({tag, " start dz clear"}, 64'(div_by_zero), 64'(0));
      check({tag, " start ov clear"}, 64'(overflow), 64'(0));
      check({tag, " start q hold"}, 64'(out_quotient), 64'(last_q));
    end
    while (k <= 100 && !seen) begin
      if (done) begin
        seen = 1;
      end else begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    check({tag, " latency"}, seen ? 64'(k) : 64'hFFFF, 64'(lat));
    go = 1'b0;
    check({tag, " quotient"}, 64'(out_quotient), 64'(eq));
    check({tag, " remainder"}, 64'(out_remainder), 64'(er));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
    check({tag, " overflow"}, 64'(overflow), 64'(eov));
    @(posedge clk);
    #1;
    check({tag, " done pulse width"}, 64'(done), 64'(0));
    check({tag, " q hold after"}, 64'(out_quotient), 64'(eq));
    last_q = eq;
  endtask

  initial begin
    int seen_done;
    reset  = 1'b1;
    go     = 1'b0;
    left   = '0;
    right  = '0;
    last_q = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset quotient", 64'(out_quotient), 64'(0));
    check("reset remainder", 64'(out_remainder), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset dz", 64'(div_by_zero), 64'(0));
    check("reset ov", 64'(overflow), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    do_op("3/2",      32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 32'h0, 1'b0, 1'b0, 50);
    do_op("-3/2",     32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 32'h0, 1'b0, 1'b0, 50);
    do_op("3/-2",     32'h0003_0000, 32'hFFFE_0000, 32'hFFFE_8000, 32'h0, 1'b0, 1'b0, 50);
    do_op("1/3",      32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 32'h0001_0000,
          1'b0, 1'b0, 50);
    do_op("-1/3",     32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 32'hFFFF_0000,
          1'b0, 1'b0, 50);
    do_op("5/0",      32'h0005_0000, 32'h0, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 1);
    do_op("1/1",      32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 50);
    do_op("0/5",      32'h0, 32'h0005_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    do_op("min/1",    32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 50);
    do_op("big/eps",  32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 50);
    do_op("min/-1",   32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 50);

    // Reset in cycle T+20 of an op: no done, everything cleared.
    @(negedge clk);
    go    = 1'b1;
    left  = 32'h0003_0000;
    right = 32'h0002_0000;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    go    = 1'b0;
    @(posedge clk);
    #1;
    check("abort quotient", 64'(out_quotient), 64'(0));
    check("abort remainder", 64'(out_remainder), 64'(0));
    check("abort dz", 64'(div_by_zero), 64'(0));
    check("abort ov", 64'(overflow), 64'(0));
    reset = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 60; k++) begin
      if (done) seen_done++;
      @(posedge clk);
      #1;
    end
    check("abort no done", 64'(seen_done), 64'(0));
    last_q = '0;

    do_op("7/2 after abort", 32'h0007_0000, 32'h0002_0000, 32'h0003_8000, 32'h0,
          1'b0, 1'b0, 50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/std_fp_div_pipe_param.md
Name: std_fp_div_pipe_param

Overview:
- Parametrised iterative restoring fixed-point divider. Handles any WIDTH/INT_WIDTH/FRAC_WIDTH split, with an optional signed mode.
- Adds behaviours the fixed 32-bit divider lacks:
  - signed operands
  - divide-by-zero and overflow flags with saturation
  - deterministic, documented latency
  - a correct fixed-point remainder
- Sits in the standard primitive library as the go/done sequential divide used by generated datapaths.

Parameters:
- WIDTH, 32, total operand/result width in bits.
- INT_WIDTH, 16, integer bits. Must satisfy INT_WIDTH + FRAC_WIDTH == WIDTH.
- FRAC_WIDTH, 16, fractional bits.
- SIGNED, 1, 1 = two's-complement operands/results, 0 = unsigned.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- go  input  1  request; held high by the caller until done.
- left  input  WIDTH  dividend, fixed-point.
- right  input  WIDTH  divisor, fixed-point.
- out_quotient  output  WIDTH  fixed-point quotient, registered.
- out_remainder  output  WIDTH  remainder of the extended division, registered.
- done  output  1  one-cycle completion pulse.
- div_by_zero  output  1  sticky until next start: last op had right == 0.
- overflow  output  1  sticky until next start: last op's quotient was saturated.

Behaviour:
- Derived constant: ITER = WIDTH + FRAC_WIDTH iterations.
- Reset: state IDLE. out_quotient, out_remainder, done, div_by_zero, overflow are all 0.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - go=1 in cycle T is the start. It latches |left|, |right| (magnitudes if SIGNED, else raw), the sign of the result (sign(left) XOR sign(right)) and sign(left).
  - It clears both flags and the idx counter.
  - Operand changes after T are ignored.
- Fast paths at start:
  - right==0: next state DONE. out_quotient = 0x7FF..F if SIGNED, else all-ones. div_by_zero=1, out_remainder=0.
  - left==0 with right!=0: next state DONE, quotient=0, remainder=0.
  - In both cases done=1 in cycle T+1.
- RUN: one restoring step per cycle over the dividend extended to |left|<<FRAC_WIDTH.
  - Accumulator is WIDTH+1 bits; quotient register is ITER bits.
  - Each step: if acc >= divisor, subtract and shift in 1, else shift in 0.
  - idx counts 0..ITER-1; the last step moves to FIX.
- FIX, one cycle:
  - Overflow check: magnitude quotient must fit in WIDTH bits (unsigned) or WIDTH-1 bits (signed).
  - Exception: a negative result of exactly 2^(WIDTH-1) is legal.
  - On overflow: saturate to max positive, or to most negative if result sign is negative (unsigned: all-ones). Set overflow=1 and remainder=0.
  - Otherwise: quotient = magnitude, negated if result sign is negative (truncation toward zero). Remainder = acc, negated if the dividend was negative.
  - Outputs are registered at the end of FIX.
- DONE: done=1 for exactly this cycle, which is T+ITER+2. Then IDLE.
  - If go is still high in the cycle after DONE, a new operation starts.
- Outputs and flags hold their values from DONE until the next start or reset.
  - At the start, outputs hold and flags clear.
- Invariant, non-saturated case: |left|<<FRAC_WIDTH == |q|*|right| + |r|, with 0 <= |r| < |right|.

Decomposition:
- Package std_fp_div_pkg holds:
  - state enum (IDLE, RUN, FIX, DONE)
  - function iterations(width, frac)
  - function sat_max(width, signed) / sat_min(width, signed)
- One sub-module, std_fp_div_step: combinational single restoring step.
  - In: acc, quotient, next dividend bit, divisor.
  - Out: acc_next, quotient_next.
  - Instantiated once and iterated in time.

Test Plan (defaults, ITER=48, start in cycle T):
- 0x00030000 / 0x00020000 (3.0/2.0) -> quotient 0x00018000, remainder 0, flags 0, done exactly in cycle T+50 and only then.
- 0xFFFD0000 / 0x00020000 (-3.0/2.0) -> quotient 0xFFFE8000 (-1.5), remainder 0. Same for 0x00030000 / 0xFFFE0000.
- 0x00010000 / 0x00030000 (1/3) -> quotient 0x00005555, remainder 0x00010000. With dividend negated -> quotient 0xFFFFAAAB, remainder 0xFFFF0000.
- 0x00050000 / 0 -> done in cycle T+1, quotient 0x7FFFFFFF, div_by_zero=1. Next op 0x00010000/0x00010000 -> div_by_zero clears at start, quotient 0x00010000.
- Overflow cases, each -> quotient 0x7FFFFFFF, overflow=1, remainder 0:
  - 0x7FFF0000 / 0x00000001
  - 0x80000000 / 0xFFFF0000 (-32768/-1)
  - And 0x80000000 / 0x00010000 -> 0x80000000, no overflow.
- Reset asserted in cycle T+20 of an op -> no done pulse, all outputs 0 next cycle. Fresh go afterwards completes normally with correct values.
